// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int FC_ADDR_W      = 16;
    localparam int FC_INSTR_W     = 32;
    localparam int PC_STEP        = 4;
    localparam int FC_STATE_WIDTH = 2;

    typedef enum logic [FC_STATE_WIDTH-1:0] {
        FC_IDLE = 2'd0,
        FC_RUN  = 2'd1,
        FC_HALT = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous first-word-fall-through FIFO holding fetched {instr, pc}.
// The head entry is visible on rd_data whenever empty is low; flush wins over push.
module fetch_buf #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; entries need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping, with flush emptying the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, the run/halt/idle FSM and the
// fetch decision; fetched words queue in fetch_buf toward decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = FC_ADDR_W,
    parameter int                INSTR_W   = FC_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic [ADDR_W-1:0]         imem_addr,
    output logic                      imem_re,
    input  logic [INSTR_W-1:0]        imem_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [FC_STATE_WIDTH-1:0] state_o,
    output logic                      misalign_err
);

    fc_state_e           state;
    fc_state_e           state_next;
    logic [ADDR_W-1:0]   pc;
    logic                pop;
    logic                push;
    logic                misaligned;
    logic                buf_full;
    logic                buf_empty;
    logic [INSTR_W+ADDR_W-1:0] head;

    assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign out_valid  = ~buf_empty;
    assign pop        = out_valid & out_ready;
    assign push       = (state == FC_RUN) & ~redirect_valid & ~halt & (~buf_full | pop);
    assign imem_re    = push;
    assign imem_addr  = pc;
    assign out_instr  = head[INSTR_W+ADDR_W-1:ADDR_W];
    assign out_pc     = head[ADDR_W-1:0];
    assign state_o    = state;

    fetch_buf #(
        .WIDTH(INSTR_W + ADDR_W),
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wr_data({imem_instr, pc}),
        .rd_data(head),
        .full   (buf_full),
        .empty  (buf_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a redirect outranks halt/start, and a bad target parks the sequencer.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            if (misaligned) begin
                state_next = FC_HALT;
            end
        end else begin
            case (state)
                FC_IDLE: if (start)          state_next = FC_RUN;
                FC_RUN:  if (halt)           state_next = FC_HALT;
                FC_HALT: if (start && !halt) state_next = FC_RUN;
                default:                     state_next = FC_IDLE;
            endcase
        end
    end

    // PC advances on each fetch and reloads on an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            if (!misaligned) begin
                pc <= redirect_pc;
            end
        end else if (push) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule
